// File: rtl/scr1_imem_cmd_monitor_if.sv
// Handshake bundle for the IMEM command monitor: core-side fetch response in, capture FIFO readout out.
// The rd_tstamp member exists only when SCR1_IMON_TIMESTAMP_EN is defined.
interface scr1_imem_cmd_monitor_if;
   logic [1:0]  imem_resp;
   logic [31:0] imem_rdata;
   logic [31:0] curr_pc;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic [2:0]  rd_ch;
`ifdef SCR1_IMON_TIMESTAMP_EN
   logic [31:0] rd_tstamp;

   modport slave (
      input  imem_resp, imem_rdata, curr_pc, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_ch, rd_tstamp
   );
   modport master (
      output imem_resp, imem_rdata, curr_pc, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_ch, rd_tstamp
   );
`else
   modport slave (
      input  imem_resp, imem_rdata, curr_pc, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_ch
   );
   modport master (
      output imem_resp, imem_rdata, curr_pc, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_ch
   );
`endif
endinterface

// File: rtl/scr1_imem_cmd_monitor.sv
// Instruction-fetch monitor: mask/match channels, saturating hit counters, capture FIFO with overflow/freeze.
// Optional macro SCR1_IMON_TIMESTAMP_EN adds a cycle-counter timestamp to every captured entry.
module scr1_imem_cmd_monitor #(
   parameter int NUM_CH         = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int CNT_W          = 16,
   parameter int FREEZE_ON_FULL = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mon_en,
   input  logic                     mon_clr,
   scr1_imem_cmd_monitor_if.slave   bus,
   input  logic [NUM_CH-1:0]        cfg_ch_en,
   input  logic [NUM_CH*32-1:0]     cfg_mask,
   input  logic [NUM_CH*32-1:0]     cfg_match,
   output logic [NUM_CH*CNT_W-1:0]  hit_cnt,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [1:0]               mon_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FROZEN = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic        s1_vld_q, s1_vld_d;
   logic [31:0] s1_instr_q;
   logic [31:0] s1_pc_q;

   logic [NUM_CH-1:0] hit;
   logic              s2_act;
   logic              any_hit;
   logic [2:0]        hit_idx;

   logic [AW:0] wptr_q, rptr_q;
   logic        empty, full, pop, push_ok, drop;

   logic [31:0] mem_pc    [FIFO_DEPTH];
   logic [31:0] mem_instr [FIFO_DEPTH];
   logic [2:0]  mem_ch    [FIFO_DEPTH];

   logic             overflow_q;
   logic [CNT_W-1:0] drop_cnt_q;

   // Stage 1: register a valid response only while actively monitoring
   assign s1_vld_d = !mon_clr && (state_q == ST_RUN) && (bus.imem_resp == 2'b01);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_instr_q <= '0;
         s1_pc_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         if (s1_vld_d) begin
            s1_instr_q <= bus.imem_rdata;
            s1_pc_q    <= bus.curr_pc;
         end
      end
   end

   // An in-flight entry still completes after RUN->IDLE, but never in FROZEN or under clear
   assign s2_act = s1_vld_q && (state_q != ST_FROZEN) && !mon_clr;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
         logic [31:0]      mask_w;
         logic [CNT_W-1:0] cnt_q;

         assign mask_w  = cfg_mask[32*gi +: 32];
         assign hit[gi] = s2_act && cfg_ch_en[gi] &&
                          ((s1_instr_q & mask_w) == (cfg_match[32*gi +: 32] & mask_w));

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               cnt_q <= '0;
            else if (mon_clr)
               cnt_q <= '0;
            else if (hit[gi] && (cnt_q != '1))
               cnt_q <= cnt_q + CNT_ONE;
         end

         assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_q;
      end
   endgenerate

   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   // Extra pointer MSB distinguishes full from empty
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop     = !empty && bus.rd_ready;
   assign push_ok = any_hit && (!full || pop);
   assign drop    = any_hit && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (mon_clr) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (push_ok)
            wptr_q <= wptr_q + PTR_ONE;
         if (pop)
            rptr_q <= rptr_q + PTR_ONE;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1)
               drop_cnt_q <= drop_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_pc[wptr_q[AW-1:0]]    <= s1_pc_q;
         mem_instr[wptr_q[AW-1:0]] <= s1_instr_q;
         mem_ch[wptr_q[AW-1:0]]    <= hit_idx;
      end
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_pc    = empty ? '0 : mem_pc[rptr_q[AW-1:0]];
   assign bus.rd_instr = empty ? '0 : mem_instr[rptr_q[AW-1:0]];
   assign bus.rd_ch    = empty ? '0 : mem_ch[rptr_q[AW-1:0]];

`ifdef SCR1_IMON_TIMESTAMP_EN
   logic [31:0] tstamp_q;
   logic [31:0] s1_ts_q;
   logic [31:0] mem_ts [FIFO_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tstamp_q <= '0;
         s1_ts_q  <= '0;
      end else begin
         tstamp_q <= mon_clr ? '0 : tstamp_q + 32'd1;
         if (s1_vld_d)
            s1_ts_q <= tstamp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_ts[wptr_q[AW-1:0]] <= s1_ts_q;
   end

   assign bus.rd_tstamp = empty ? '0 : mem_ts[rptr_q[AW-1:0]];
`endif

   always_comb begin
      state_d = state_q;
      if (mon_clr) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (mon_en) state_d = ST_RUN;
            ST_RUN: begin
               if ((FREEZE_ON_FULL != 0) && drop)
                  state_d = ST_FROZEN;
               else if (!mon_en)
                  state_d = ST_IDLE;
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign mon_state = state_q;

endmodule
